// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the fetch requester (f_*), the data
// requester (d_*), the shared memory port (mem_*) and debug status.
//   master : the arbiter side (drives grants, done pulses, rdata and mem_*)
//   slave  : the CPU stages plus memory model (drive requests, mem_ready/rdata)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_done;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              timeout;
    logic [1:0]        arb_state;

    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, timeout, arb_state
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, timeout, arb_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch stage (F) and
// the load/store stage (D) with round-robin priority on conflicts. Each grant
// runs one req/ready transaction with a bounded wait and a one-cycle done.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - mem_port_arbiter_if.master (requests, grants, mem port, debug)
//
// state  | meaning
// IDLE   | port free; f_req/d_req sampled here only
// BUSY_F | fetch owns the port, waiting for mem_ready
// BUSY_D | data access owns the port, waiting for mem_ready
// RESP   | done pulse to owner (plus timeout if aborted), back to IDLE
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.master    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_F = 2'b01,
        BUSY_D = 2'b10,
        RESP   = 2'b11
    } arb_state_t;

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int CNT_LAST_I = (MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    arb_state_t        state_q, state_d;
    logic              last_owner_q, last_owner_d;   // 1 = D won the last conflict
    logic              owner_q, owner_d;             // 1 = D owns current transaction
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              timeout_q, timeout_d;

    logic start;
    logic pick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            wait_cnt_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        wait_cnt_d   = wait_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        timeout_d    = 1'b0;            // only ever high for the RESP cycle
        start        = 1'b0;
        pick_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.f_req && bus.d_req) begin
                    start        = 1'b1;
                    pick_d       = !last_owner_q;
                    last_owner_d = !last_owner_q;
                end else if (bus.f_req) begin
                    start = 1'b1;
                end else if (bus.d_req) begin
                    start  = 1'b1;
                    pick_d = 1'b1;
                end
                if (start) begin
                    state_d     = pick_d ? BUSY_D : BUSY_F;
                    owner_d     = pick_d;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_d && bus.d_we;
                    mem_addr_d  = pick_d ? bus.d_addr : bus.f_addr;
                    mem_wdata_d = pick_d ? bus.d_wdata : '0;
                    wait_cnt_d  = '0;
                end
            end
            BUSY_F, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        if (owner_q) d_rdata_d = bus.mem_rdata;
                        else         f_rdata_d = bus.mem_rdata;
                    end
                end else if ((MAX_WAIT > 0) && (wait_cnt_q == CNT_LAST)) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                end else if (wait_cnt_q != CNT_SAT) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.f_gnt     = (state_q == BUSY_F);
    assign bus.d_gnt     = (state_q == BUSY_D);
    assign bus.f_done    = (state_q == RESP) && !owner_q;
    assign bus.d_done    = (state_q == RESP) && owner_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.timeout   = timeout_q;
    assign bus.arb_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.f_req     = 1'b0;
        bus.f_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_state",   32'(bus.arb_state), 32'd0);
        chk("rst_f_gnt",   32'(bus.f_gnt),     32'd0);
        chk("rst_d_gnt",   32'(bus.d_gnt),     32'd0);
        chk("rst_done",    32'({bus.f_done, bus.d_done}), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req),   32'd0);
        chk("rst_mem_we",  32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,    32'd0);
        chk("rst_f_rdata", bus.f_rdata,        32'd0);
        chk("rst_d_rdata", bus.d_rdata,        32'd0);
        chk("rst_timeout", 32'(bus.timeout),   32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single fetch, ready in first BUSY cycle
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0004;
        cyc();
        chk("sf_state_busy", 32'(bus.arb_state), 32'd1);
        chk("sf_f_gnt",      32'(bus.f_gnt),     32'd1);
        chk("sf_d_gnt",      32'(bus.d_gnt),     32'd0);
        chk("sf_mem_req",    32'(bus.mem_req),   32'd1);
        chk("sf_mem_addr",   32'(bus.mem_addr),  32'h0004);
        chk("sf_mem_we_busy", 32'(bus.mem_we),   32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hAAAAAAAA;
        cyc();
        chk("sf_state_resp", 32'(bus.arb_state), 32'd3);
        chk("sf_f_done",     32'(bus.f_done),    32'd1);
        chk("sf_d_done",     32'(bus.d_done),    32'd0);
        chk("sf_f_gnt_resp", 32'(bus.f_gnt),     32'd0);
        chk("sf_mem_req_resp", 32'(bus.mem_req), 32'd0);
        chk("sf_f_rdata",    bus.f_rdata,        32'hAAAAAAAA);
        chk("sf_timeout",    32'(bus.timeout),   32'd0);
        chk("sf_mem_we_resp", 32'(bus.mem_we),   32'd0);
        bus.f_req     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        cyc();
        chk("sf_state_idle", 32'(bus.arb_state), 32'd0);
        chk("sf_f_done_once", 32'(bus.f_done),   32'd0);
        chk("sf_f_rdata_hold", bus.f_rdata,      32'hAAAAAAAA);

        // Conflict and fairness: F, D, F, D
        do_reset();
        bus.f_req     = 1'b1;
        bus.d_req     = 1'b1;
        bus.f_addr    = 16'h0020;
        bus.d_addr    = 16'h0030;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_d;
            exp_d = (i % 2) == 1;
            bus.mem_rdata = 32'h1000_0000 + 32'(i);
            cyc();
            chk($sformatf("cf%0d_f_gnt", i), 32'(bus.f_gnt), exp_d ? 32'd0 : 32'd1);
            chk($sformatf("cf%0d_d_gnt", i), 32'(bus.d_gnt), exp_d ? 32'd1 : 32'd0);
            chk($sformatf("cf%0d_addr", i), 32'(bus.mem_addr), exp_d ? 32'h0030 : 32'h0020);
            cyc();
            chk($sformatf("cf%0d_f_done", i), 32'(bus.f_done), exp_d ? 32'd0 : 32'd1);
            chk($sformatf("cf%0d_d_done", i), 32'(bus.d_done), exp_d ? 32'd1 : 32'd0);
            if (exp_d) begin
                chk($sformatf("cf%0d_d_rdata", i), bus.d_rdata, 32'h1000_0000 + 32'(i));
                bus.d_req = 1'b0;
            end else begin
                chk($sformatf("cf%0d_f_rdata", i), bus.f_rdata, 32'h1000_0000 + 32'(i));
                bus.f_req = 1'b0;
            end
            cyc();
            chk($sformatf("cf%0d_idle", i), 32'(bus.arb_state), 32'd0);
            if (exp_d) bus.d_req = 1'b1;
            else       bus.f_req = 1'b1;
        end
        bus.f_req     = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        cyc();

        // Data write with 3 wait states
        do_reset();
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 16'h0010;
        bus.d_wdata   = 32'hBBBBBBBB;
        bus.mem_rdata = 32'h12345678;
        cyc();
        bus.d_wdata   = 32'h0;
        bus.d_addr    = 16'h0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("wr%0d_state", j), 32'(bus.arb_state), 32'd2);
            chk($sformatf("wr%0d_addr", j), 32'(bus.mem_addr), 32'h0010);
            chk($sformatf("wr%0d_wdata", j), bus.mem_wdata, 32'hBBBBBBBB);
            chk($sformatf("wr%0d_we", j), 32'(bus.mem_we), 32'd1);
            chk($sformatf("wr%0d_req", j), 32'(bus.mem_req), 32'd1);
            if (j == 3) bus.mem_ready = 1'b1;
            cyc();
        end
        chk("wr_d_done",  32'(bus.d_done),   32'd1);
        chk("wr_timeout", 32'(bus.timeout),  32'd0);
        chk("wr_d_rdata", bus.d_rdata,       32'd0);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        cyc();
        chk("wr_d_done_once", 32'(bus.d_done), 32'd0);
        chk("wr_d_rdata_idle", bus.d_rdata,    32'd0);

        // Read to preload d_rdata, then a timed-out read
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 16'h0040;
        cyc();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A5A5A;
        cyc();
        chk("pre_d_rdata", bus.d_rdata, 32'h5A5A5A5A);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        cyc();

        bus.d_req     = 1'b1;
        bus.d_addr    = 16'h0044;
        bus.mem_rdata = 32'hFFFFFFFF;
        cyc();
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("to%0d_busy", k), 32'(bus.arb_state), 32'd2);
            cyc();
        end
        chk("to_state_resp", 32'(bus.arb_state), 32'd3);
        chk("to_d_done",     32'(bus.d_done),    32'd1);
        chk("to_timeout",    32'(bus.timeout),   32'd1);
        chk("to_mem_req",    32'(bus.mem_req),   32'd0);
        chk("to_d_rdata",    bus.d_rdata,        32'h5A5A5A5A);
        bus.d_req = 1'b0;
        cyc();
        chk("to_timeout_clr", 32'(bus.timeout),  32'd0);
        chk("to_idle",        32'(bus.arb_state), 32'd0);

        // Reset in the middle of BUSY_F
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0008;
        cyc();
        chk("rm_busy_f", 32'(bus.arb_state), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rm_mem_req",  32'(bus.mem_req),   32'd0);
        chk("rm_f_gnt",    32'(bus.f_gnt),     32'd0);
        chk("rm_state",    32'(bus.arb_state), 32'd0);
        chk("rm_mem_addr", 32'(bus.mem_addr),  32'd0);
        bus.f_req = 1'b0;
        for (int m = 0; m < 3; m++) begin
            cyc();
            chk($sformatf("rm%0d_no_done", m), 32'(bus.f_done), 32'd0);
        end
        @(negedge clk);
        reset     = 1'b1;
        bus.f_req = 1'b1;
        bus.d_req = 1'b1;
        chk("rm_rel_no_done", 32'(bus.f_done), 32'd0);
        cyc();
        chk("rm_conf_f_gnt", 32'(bus.f_gnt), 32'd1);
        chk("rm_conf_d_gnt", 32'(bus.d_gnt), 32'd0);
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
